// File: rtl/instr_loader_if.sv
// instr_loader_if
// Pin-side bus of the instruction loader. CLK and RESET stay outside as plain
// ports.
//   DIN[2:0]          program chunk, MSB-first         (master -> slave)
//   DIN_VALID         DIN holds a chunk this cycle     (master -> slave)
//   LOAD              level, requests/holds a load     (master -> slave)
//   START             issue the buffered program       (master -> slave)
//   STALL             hold issue                       (master -> slave)
//   INSTRUCTION[8:0]  word presented to the CPU        (slave -> master)
//   write_en          INSTRUCTION valid this cycle     (slave -> master)
//   BUSY              loader is in LOAD or RUN         (slave -> master)
//   COUNT[AW:0]       complete words stored            (slave -> master)
//   DONE              program fully issued             (slave -> master)
interface instr_loader_if #(
  parameter int AW = 3
);
  logic [2:0]  DIN;
  logic        DIN_VALID;
  logic        LOAD;
  logic        START;
  logic        STALL;
  logic [8:0]  INSTRUCTION;
  logic        write_en;
  logic        BUSY;
  logic [AW:0] COUNT;
  logic        DONE;

  modport master (
    output DIN, DIN_VALID, LOAD, START, STALL,
    input  INSTRUCTION, write_en, BUSY, COUNT, DONE
  );

  modport slave (
    input  DIN, DIN_VALID, LOAD, START, STALL,
    output INSTRUCTION, write_en, BUSY, COUNT, DONE
  );
endinterface

// File: rtl/instr_loader.sv
// instr_loader
// Assembles 9-bit instructions from 3-bit chunks arriving on narrow pins,
// stores up to DEPTH of them, and replays the buffer one word per cycle onto
// the CPU instruction/write-enable inputs, honouring STALL.
// Ports:
//   CLK    rising-edge clock
//   RESET  synchronous, active-low reset (0 = reset)
//   bus    instr_loader_if.slave (chunk input, control, CPU-facing outputs)
// All outputs are registered.
module instr_loader #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic            CLK,
  input  logic            RESET,
  instr_loader_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_FIN  = 2'd3
  } state_e;

  localparam logic [AW:0] COUNT_FULL_M1 = (AW+1)'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [5:0]    asm_q,   asm_d;     // first two chunks of the word in flight
  logic [1:0]    chunk_q, chunk_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [8:0]    instr_q, instr_d;
  logic          we_q,    we_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;

  logic [8:0]    mem_q [DEPTH];
  logic          mem_we;
  logic [8:0]    mem_wdata;

  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d   = state_q;
    asm_d     = asm_q;
    chunk_d   = chunk_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    instr_d   = instr_q;
    we_d      = 1'b0;
    done_d    = done_q;
    mem_we    = 1'b0;
    mem_wdata = {asm_q, bus.DIN};

    unique case (state_q)
      S_IDLE: begin
        if (bus.LOAD) begin
          state_d  = S_LOAD;
          wr_ptr_d = '0;
          count_d  = '0;
          chunk_d  = '0;
          done_d   = 1'b0;
        end else if (bus.START && (count_q != '0)) begin
          state_d  = S_RUN;
          rd_ptr_d = '0;
        end
      end

      S_LOAD: begin
        if (!bus.LOAD) begin
          // Session ended: drop any partial word, keep completed ones.
          state_d = S_IDLE;
          chunk_d = '0;
        end else if (bus.DIN_VALID) begin
          asm_d = {asm_q[2:0], bus.DIN};
          if (chunk_q == 2'd2) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
            chunk_d  = '0;
            if (count_q == COUNT_FULL_M1) begin
              state_d = S_IDLE;
            end
          end else begin
            chunk_d = chunk_q + 1'b1;
          end
        end
      end

      S_RUN: begin
        if (!bus.STALL) begin
          instr_d  = mem_q[rd_ptr_q];
          we_d     = 1'b1;
          rd_ptr_d = rd_ptr_q + 1'b1;
          if ({1'b0, rd_ptr_q} == (count_q - 1'b1)) begin
            state_d = S_FIN;
          end
        end
      end

      S_FIN: begin
        done_d = 1'b1;
        if (bus.LOAD) begin
          state_d  = S_LOAD;
          wr_ptr_d = '0;
          count_d  = '0;
          chunk_d  = '0;
          done_d   = 1'b0;
        end else if (bus.START) begin
          state_d  = S_RUN;
          rd_ptr_d = '0;
          done_d   = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // A reset edge must not commit a buffer write.
    if (!RESET) begin
      mem_we = 1'b0;
    end
  end

  assign busy_d = (state_d == S_LOAD) || (state_d == S_RUN);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      asm_q    <= '0;
      chunk_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      instr_q  <= '0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      asm_q    <= asm_d;
      chunk_q  <= chunk_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      instr_q  <= instr_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // NOTE: the buffer has no reset; it is unreachable while COUNT=0, and
  // leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= mem_wdata;
    end
  end

  assign bus.INSTRUCTION = instr_q;
  assign bus.write_en    = we_q;
  assign bus.BUSY        = busy_q;
  assign bus.COUNT       = count_q;
  assign bus.DONE        = done_q;

endmodule
